// File: rtl/seq_alu_accum_if.sv
// Operation/result bus of the sequential ALU/accumulator.
//   op_valid, opcode, operand_a : operation request (master -> slave)
//   op_ready                    : slave can accept an operation
//   acc                         : accumulator, 2*WIDTH bits, registered
//   result_valid                : one-cycle pulse after acc was written by an op
//   zero                        : acc == 0 (combinational)
//   overflow                    : carry-out flag of the last completed op
interface seq_alu_accum_if #(
  parameter int WIDTH = 4
);
  logic                   op_valid;
  logic                   op_ready;
  logic [2:0]             opcode;
  logic [WIDTH-1:0]       operand_a;
  logic [2*WIDTH-1:0]     acc;
  logic                   result_valid;
  logic                   zero;
  logic                   overflow;

  modport master (
    output op_valid, opcode, operand_a,
    input  op_ready, acc, result_valid, zero, overflow
  );

  modport slave (
    input  op_valid, opcode, operand_a,
    output op_ready, acc, result_valid, zero, overflow
  );
endinterface

// File: rtl/seq_alu_accum.sv
// Sequential ALU/accumulator. Operand A comes with an opcode on the bus,
// operand B is the low WIDTH bits of the 2*WIDTH-bit accumulator, and the
// result is written back into the accumulator. All ops finish in the accept
// cycle except MUL, which runs a WIDTH-cycle shift-add sequence.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   clear   : synchronous clear of acc/flags/state, overrides everything
//   bus     : seq_alu_accum_if.slave (handshake, operand, acc and flags)
module seq_alu_accum #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            clear,
  seq_alu_accum_if.slave  bus
);

  localparam int ACC_W = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef logic [ACC_W-1:0] acc_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic {S_IDLE, S_MUL} state_t;

  localparam logic [2:0] OP_INC   = 3'b111;
  localparam logic [2:0] OP_ACCUM = 3'b110;
  localparam logic [2:0] OP_ADD   = 3'b101;
  localparam logic [2:0] OP_PACK  = 3'b100;
  localparam logic [2:0] OP_ORR   = 3'b011;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b000;

  localparam acc_t ACC_W_V = acc_t'(ACC_W);

  // Full-width accumulate: clamp on carry-out when SATURATE, else wrap.
  function automatic acc_t sat_accum(input logic [ACC_W:0] sum);
    if (SATURATE && sum[ACC_W]) return '1;
    return sum[ACC_W-1:0];
  endfunction

  // Logical shift where any amount >= ACC_W flushes to zero.
  function automatic acc_t shift_val(input acc_t val, input acc_t amt, input logic left);
    if (amt >= ACC_W_V) return '0;
    return left ? (val << amt) : (val >> amt);
  endfunction

  state_t             state_q, state_d;
  acc_t               acc_q;
  logic               ovf_q;
  logic               rv_q;

  acc_t               mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  acc_t               part_q;
  cnt_t               cnt_q;

  logic [WIDTH-1:0]   op_b;
  acc_t               a_ext, b_ext;
  logic [ACC_W:0]     accum_sum;
  acc_t               alu_res;
  logic               alu_ovf;
  acc_t               step_sum;
  logic               mul_last;
  logic               accept;
  logic               is_mul;

  assign op_b     = acc_q[WIDTH-1:0];
  assign accept   = bus.op_valid && (state_q == S_IDLE) && !clear;
  assign is_mul   = (bus.opcode == OP_MUL);
  // Partial product including the current multiplier bit; on the last
  // iteration this is already the final product.
  assign step_sum = part_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (cnt_q == cnt_t'(WIDTH - 1));

  assign bus.op_ready     = (state_q == S_IDLE);
  assign bus.acc          = acc_q;
  assign bus.result_valid = rv_q;
  assign bus.overflow     = ovf_q;
  assign bus.zero         = (acc_q == '0);

  always_comb begin
    a_ext     = acc_t'(bus.operand_a);
    b_ext     = acc_t'(op_b);
    accum_sum = {1'b0, acc_q} + {1'b0, a_ext};
    alu_res   = '0;
    alu_ovf   = 1'b0;
    case (bus.opcode)
      OP_INC:   alu_res = a_ext + acc_t'(1);
      OP_ACCUM: begin
        alu_res = sat_accum(accum_sum);
        alu_ovf = accum_sum[ACC_W];
      end
      OP_ADD:   alu_res = a_ext + b_ext;
      OP_PACK:  alu_res = {bus.operand_a | op_b, bus.operand_a ^ op_b};
      OP_ORR:   alu_res = acc_t'((|bus.operand_a) | (|op_b));
      OP_SHL:   alu_res = shift_val(b_ext, a_ext, 1'b1);
      OP_SHR:   alu_res = shift_val(b_ext, a_ext, 1'b0);
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept && is_mul) state_d = S_MUL;
        S_MUL:   if (mul_last) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control and architectural state: acc, flags, FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rv_q    <= 1'b0;
      if (clear) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else if (state_q == S_IDLE) begin
        if (accept && !is_mul) begin
          acc_q <= alu_res;
          ovf_q <= alu_ovf;
          rv_q  <= 1'b1;
        end
      end else if (mul_last) begin
        acc_q <= step_sum;
        ovf_q <= 1'b0;
        rv_q  <= 1'b1;
      end
    end
  end

  // Multiplier datapath: operands latched at accept, one bit per MUL cycle
  always_ff @(posedge clock) begin
    if (state_q == S_IDLE) begin
      if (accept) begin
        mcand_q  <= a_ext;
        mplier_q <= op_b;
        part_q   <= '0;
        cnt_q    <= '0;
      end
    end else begin
      part_q   <= step_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + cnt_t'(1);
    end
  end

endmodule

// File: tb/tb_seq_alu_accum.sv
module tb_seq_alu_accum;
  localparam int W = 4;

  localparam logic [2:0] INC = 3'b111, ACCUM = 3'b110, ADD = 3'b101, PACK = 3'b100;
  localparam logic [2:0] ORR = 3'b011, SHL = 3'b010, SHR = 3'b001, MUL = 3'b000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  seq_alu_accum_if #(.WIDTH(W)) if0 ();
  seq_alu_accum_if #(.WIDTH(W)) if1 ();

  assign if1.op_valid  = if0.op_valid;
  assign if1.opcode    = if0.opcode;
  assign if1.operand_a = if0.operand_a;

  seq_alu_accum #(.WIDTH(W), .SATURATE(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .bus(if0));
  seq_alu_accum #(.WIDTH(W), .SATURATE(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .bus(if1));

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] m_acc0, m_acc1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one operation on an 8-bit accumulator.
  function automatic void model(input logic [2:0] op, input logic [3:0] a,
                                input logic [7:0] acc, input bit sat,
                                output logic [7:0] r, output logic ov);
    logic [3:0] b;
    logic [8:0] s;
    b  = acc[3:0];
    ov = 1'b0;
    r  = 8'h00;
    case (op)
      INC:   r = {4'h0, a} + 8'd1;
      ACCUM: begin
        s  = {1'b0, acc} + {5'h00, a};
        ov = s[8];
        r  = (sat && ov) ? 8'hFF : s[7:0];
      end
      ADD:   r = {4'h0, a} + {4'h0, b};
      PACK:  r = {a | b, a ^ b};
      ORR:   r = (a != 4'h0 || b != 4'h0) ? 8'h01 : 8'h00;
      SHL:   r = (a >= 4'd8) ? 8'h00 : ({4'h0, b} << a);
      SHR:   r = (a >= 4'd8) ? 8'h00 : ({4'h0, b} >> a);
      default: r = {4'h0, a} * {4'h0, b};
    endcase
  endfunction

  // Scoreboard consumer: every result_valid pulse must match the oldest entry.
  always @(negedge clock) begin
    logic [8:0] e;
    if (if0.result_valid === 1'b1) begin
      if (q0.size() == 0) check("rv0_unexpected", 32'(if0.result_valid), 32'd0);
      else begin
        e = q0.pop_front();
        check("acc0", 32'(if0.acc), 32'(e[7:0]));
        check("ovf0", 32'(if0.overflow), 32'(e[8]));
        check("zero0", 32'(if0.zero), 32'(e[7:0] == 8'h00));
      end
    end
    if (if1.result_valid === 1'b1) begin
      if (q1.size() == 0) check("rv1_unexpected", 32'(if1.result_valid), 32'd0);
      else begin
        e = q1.pop_front();
        check("acc1", 32'(if1.acc), 32'(e[7:0]));
        check("ovf1", 32'(if1.overflow), 32'(e[8]));
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [3:0] a);
    @(negedge clock);
    if0.op_valid  = 1'b1;
    if0.opcode    = op;
    if0.operand_a = a;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] a);
    logic [7:0] r;
    logic ov;
    @(negedge clock);
    check("op_ready_before_issue", 32'(if0.op_ready), 32'd1);
    if0.op_valid  = 1'b1;
    if0.opcode    = op;
    if0.operand_a = a;
    model(op, a, m_acc0, 1'b0, r, ov);
    q0.push_back({ov, r});
    m_acc0 = r;
    model(op, a, m_acc1, 1'b1, r, ov);
    q1.push_back({ov, r});
    m_acc1 = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if0.op_valid = 1'b0;
    end
  endtask

  task automatic do_clear();
    @(negedge clock);
    if0.op_valid = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clear_acc0", 32'(if0.acc), 32'd0);
    check("clear_acc1", 32'(if1.acc), 32'd0);
    check("clear_ovf0", 32'(if0.overflow), 32'd0);
    m_acc0 = 8'h00;
    m_acc1 = 8'h00;
  endtask

  task automatic load(input logic [3:0] v);
    do_clear();
    issue(ADD, v);
  endtask

  initial begin
    logic [7:0] pre;
    if0.op_valid  = 1'b0;
    if0.opcode    = 3'b000;
    if0.operand_a = 4'h0;
    m_acc0 = 8'h00;
    m_acc1 = 8'h00;

    // Reset, then release
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_acc", 32'(if0.acc), 32'h00);
    check("rst_ready", 32'(if0.op_ready), 32'd1);
    check("rst_rv", 32'(if0.result_valid), 32'd0);
    check("rst_zero", 32'(if0.zero), 32'd1);
    check("rst_ovf", 32'(if0.overflow), 32'd0);

    // INC then back-to-back ADD
    issue(INC, 4'hF);
    issue(ADD, 4'h9);
    idle(2);

    // PACK, ACCUM overflow (wrap vs saturate), INC clears overflow
    do_clear();
    issue(PACK, 4'hF);
    issue(ACCUM, 4'h1);
    issue(INC, 4'h0);
    idle(2);

    // ADD producing a WIDTH+1 bit result
    load(4'hF);
    issue(ADD, 4'hF);
    idle(2);

    // MUL with op_valid held high for the whole busy period
    load(4'h7);
    pre = m_acc0;
    issue(MUL, 4'hD);
    for (int i = 0; i < W; i++) begin
      @(negedge clock);
      check("mul_busy_ready", 32'(if0.op_ready), 32'd0);
      check("mul_busy_acc", 32'(if0.acc), 32'(pre));
    end
    @(negedge clock);
    check("mul_done_ready", 32'(if0.op_ready), 32'd1);
    if0.op_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("mul_after_ready", 32'(if0.op_ready), 32'd1);
    end
    check("mul_q0_drained", 32'(q0.size()), 32'd0);

    // Shifts and reduction-OR
    load(4'h3);
    issue(SHL, 4'd5);
    load(4'h3);
    issue(SHL, 4'd9);
    load(4'hC);
    issue(SHR, 4'd2);
    issue(ORR, 4'h0);
    do_clear();
    issue(ORR, 4'h0);
    idle(2);

    // clear on the 2nd busy cycle of a MUL aborts it
    load(4'h5);
    drive(MUL, 4'h3);
    @(negedge clock);
    if0.op_valid = 1'b0;
    check("abort_busy_ready", 32'(if0.op_ready), 32'd0);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    m_acc0 = 8'h00;
    m_acc1 = 8'h00;
    check("abort_acc", 32'(if0.acc), 32'h00);
    check("abort_ready", 32'(if0.op_ready), 32'd1);
    check("abort_rv", 32'(if0.result_valid), 32'd0);
    idle(5);

    // clear together with op_valid: the op is dropped
    load(4'h5);
    @(negedge clock);
    if0.op_valid  = 1'b1;
    if0.opcode    = INC;
    if0.operand_a = 4'h3;
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    if0.op_valid = 1'b0;
    m_acc0 = 8'h00;
    m_acc1 = 8'h00;
    check("clr_op_acc", 32'(if0.acc), 32'h00);
    check("clr_op_rv", 32'(if0.result_valid), 32'd0);
    idle(2);

    // reset_n asserted mid-MUL
    load(4'h5);
    drive(MUL, 4'h3);
    @(negedge clock);
    if0.op_valid = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    m_acc0 = 8'h00;
    m_acc1 = 8'h00;
    check("rstmul_acc", 32'(if0.acc), 32'h00);
    check("rstmul_acc1", 32'(if1.acc), 32'h00);
    check("rstmul_ready", 32'(if0.op_ready), 32'd1);
    check("rstmul_rv", 32'(if0.result_valid), 32'd0);
    check("rstmul_zero", 32'(if0.zero), 32'd1);
    check("rstmul_ovf", 32'(if0.overflow), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    idle(5);
    issue(INC, 4'h0);
    idle(3);

    check("q0_empty", 32'(q0.size()), 32'd0);
    check("q1_empty", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_alu_accum.md
Name: seq_alu_accum

Overview:
- Parametrised, handshaked successor to the lab ALU/accumulator datapath.
- Operand A arrives with an opcode. Operand B is always the low WIDTH bits of an internal accumulator register.
- The result is written back into the accumulator, which is 2*WIDTH bits wide.
- Adds a multi-cycle shift-add multiplier, a full-width accumulate op with optional saturation, valid/ready handshake, status flags and a synchronous clear. Sits between the switch/key input logic and the hex display drivers.

Parameters:
- WIDTH, 4, operand width in bits; must be >= 2. The accumulator width ACC_W = 2*WIDTH is derived, not a parameter.
- SATURATE, 0, ACCUM op behaviour on carry-out: 1 clamps the result to all-ones, 0 wraps.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of the accumulator and the state machine.
- op_valid  in  1  opcode/operand_a are valid this cycle.
- op_ready  out  1  block can accept an operation.
- opcode  in  3  operation select (see Behaviour).
- operand_a  in  WIDTH  operand A.
- acc  out  ACC_W  accumulator register (registered output).
- result_valid  out  1  one-cycle pulse when acc has just been written by a completed op.
- zero  out  1  combinational: acc == 0.
- overflow  out  1  registered carry-out flag of the last completed op.

Behaviour:
- Reset (reset_n low, asynchronous): acc=0, overflow=0, result_valid=0, state=IDLE, op_ready=1, zero=1.
- Operation is accepted on a rising edge with op_valid && op_ready. op_ready = (state==IDLE). op_valid while op_ready=0 is ignored; nothing is queued.
- B = acc[WIDTH-1:0], sampled at the acceptance edge. All results are zero-extended to ACC_W.
- Opcodes:
  - 111 INC: A+1.
  - 110 ACCUM: acc + zero-extended A, full ACC_W width.
  - 101 ADD: A+B (WIDTH+1 bits).
  - 100 PACK: {A|B, A^B}.
  - 011 ORR: reduction-OR of A and B (1 bit).
  - 010 SHL: B << A.
  - 001 SHR: B >> A (logical).
  - 000 MUL: A*B.
- Shifts: a shift amount >= ACC_W gives 0. No sign handling anywhere.
- Single-cycle ops (all except MUL): acc is written at the acceptance edge. result_valid=1 for the following cycle. op_ready stays 1, so back-to-back ops are accepted every cycle.
- overflow: written on every completed op. For ACCUM it is the carry-out of bit ACC_W-1; for every other op it is 0.
- ACCUM with carry-out: SATURATE=1 gives acc = all-ones; SATURATE=0 gives the wrapped sum.
- State machine states: IDLE, MUL.
  - IDLE -> MUL on acceptance of opcode 000. At that edge, latch the multiplicand (A), latch the multiplier (B), clear the partial product, set counter=0.
  - In MUL, on each edge: if the current multiplier bit is 1, add the shifted multiplicand to the partial product; then counter+1.
  - On the WIDTH-th MUL edge: acc <= product, overflow <= 0, result_valid pulses the next cycle, state -> IDLE.
  - Acceptance edge to acc update: WIDTH edges. op_ready=0 throughout MUL. acc holds its old value until the final write.
- clear: synchronous, highest priority over acceptance and MUL iteration. On the edge it is sampled high: acc=0, overflow=0, state=IDLE, no result_valid pulse. An in-flight MUL is aborted and its result is discarded. clear with op_valid in the same cycle: the op is not accepted.
- reset_n asserted mid-MUL: immediate abort to the reset values.
- zero follows acc combinationally in every state, including during MUL.

Test Plan:
- Reset, then release -> acc=0x00, op_ready=1, result_valid=0, zero=1, overflow=0 (WIDTH=4 for all cases).
- INC A=0xF -> next cycle acc=0x10, result_valid=1 for exactly 1 cycle, zero=0. Then back-to-back ADD A=0x9 (B=0x0) on the following cycle -> acc=0x09.
- PACK A=0xF with acc=0x00 -> acc=0xFF. Then ACCUM A=0x1:
  - SATURATE=0 -> acc=0x00, overflow=1, zero=1.
  - SATURATE=1 -> acc=0xFF, overflow=1.
  - A following INC -> overflow=0.
- acc=0x07, MUL A=0xD, op_valid held high throughout -> op_ready=0 for 4 cycles, acc stays 0x07, then acc=0x5B with a single result_valid pulse. No second MUL starts until op_ready=1.
- acc=0x03:
  - SHL A=5 -> acc=0x60.
  - Reload acc=0x03, SHL A=9 -> acc=0x00.
  - acc=0x0C, SHR A=2 -> acc=0x03.
  - ORR A=0 with B=0 -> acc=0x00.
- Start MUL, assert clear on the 2nd busy cycle -> acc=0x00 next edge, op_ready=1, no result_valid. Repeat with reset_n low mid-MUL -> immediate reset values.
